// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions.
//  DATA_W / ADDR_W / OP_W : default datapath, register-address and ALU-op widths
//  alu_op_e               : ALU operation encodings
//  REG_ZERO               : hardwired-zero register address
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/alu_operand_stage_if.sv
// Bus between decode/writeback and the operand stage, and from the stage to the ALU.
//  issue side : in_valid/in_ready, rs_addr, rt_addr, imm16, use_imm, imm_zext, op_in
//  write port : wr_en, wr_addr, wr_data
//  ALU side   : out_valid/out_ready, alu_a, alu_b, alu_op, rt_data
//  master = decode/ALU environment, slave = alu_operand_stage
interface alu_operand_stage_if #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int OP_W   = mips_pkg::OP_W
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [15:0]       imm16;
  logic              use_imm;
  logic              imm_zext;
  logic [OP_W-1:0]   op_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] rt_data;

  modport master (
    output in_valid, rs_addr, rt_addr, imm16, use_imm, imm_zext, op_in,
           wr_en, wr_addr, wr_data, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_op, rt_data
  );

  modport slave (
    input  in_valid, rs_addr, rt_addr, imm16, use_imm, imm_zext, op_in,
           wr_en, wr_addr, wr_data, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_op, rt_data
  );
endinterface

// File: rtl/regfile_2r1w.sv
// MIPS register file: two async read ports, one sync write port, $0 hardwired to 0.
//  clk, rst                    : clock, synchronous active-high reset (clears all regs)
//  wr_en_i/wr_addr_i/wr_data_i : write port (writes to $0 dropped)
//  ra_addr_i -> ra_data_o      : read port A
//  rb_addr_i -> rb_data_o      : read port B
// Build option REGFILE_BYPASS_EN: a read of the register being written this cycle
// returns wr_data_i (write-before-read); otherwise the old value is returned.
module regfile_2r1w import mips_pkg::*; #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] ra_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  input  logic [ADDR_W-1:0] rb_addr_i,
  output logic [DATA_W-1:0] rb_data_o
);
  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en_i && wr_addr_i != ADDR_W'(REG_ZERO)) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(REG_ZERO)) return '0;
`ifdef REGFILE_BYPASS_EN
    // No forwarding during reset: that write never lands.
    if (wr_en_i && !rst && wr_addr_i == a) return wr_data_i;
`endif
    return regs_q[a];
  endfunction

  assign ra_data_o = rd(ra_addr_i);
  assign rb_data_o = rd(rb_addr_i);
endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the ALU. Reads rs/rt from the register file, builds
// operand B (R[rt] or sign/zero-extended imm16) and registers {A, B, op, R[rt]} in a
// one-entry valid/ready buffer.
//  clk, rst : clock, synchronous active-high reset
//  bus      : alu_operand_stage_if.slave (issue, writeback port, ALU output)
// Build option REGFILE_BYPASS_EN: same-cycle write data forwarded to rs/rt reads.
module alu_operand_stage import mips_pkg::*; #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int OP_W   = mips_pkg::OP_W
) (
  input logic                 clk,
  input logic                 rst,
  alu_operand_stage_if.slave  bus
);
  logic [DATA_W-1:0] rs_val, rt_val, imm_ext, b_sel;
  logic              accept;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, rt_q, rt_d;
  logic [OP_W-1:0]   op_q, op_d;

  regfile_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .ra_addr_i (bus.rs_addr),
    .ra_data_o (rs_val),
    .rb_addr_i (bus.rt_addr),
    .rb_data_o (rt_val)
  );

  assign imm_ext = bus.imm_zext ? {{(DATA_W-16){1'b0}}, bus.imm16}
                                : {{(DATA_W-16){bus.imm16[15]}}, bus.imm16};
  assign b_sel   = bus.use_imm ? imm_ext : rt_val;

  // Buffer can take a new entry when empty or when its current entry leaves now.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rt_d        = rt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      a_d         = rs_val;
      b_d         = b_sel;
      op_d        = bus.op_in;
      rt_d        = rt_val;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rt_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rt_q        <= rt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.rt_data   = rt_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: reference regfile/buffer model with a
// scoreboard queue, plus directed checks for the documented scenarios.
module tb_alu_operand_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_operand_stage_if bus ();

  alu_operand_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] rt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mregs [32];
  logic        mdl_vld = 1'b0;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
`endif
    return mregs[a];
  endfunction

  // Reference model evaluated mid-cycle, while inputs are stable for the next edge.
  always @(negedge clk) begin
    logic acc;
    exp_t e;
    if (rst) begin
      mdl_vld = 1'b0;
      sb.delete();
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    end else begin
      chk("in_ready", 32'(bus.in_ready), 32'(!mdl_vld || bus.out_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(mdl_vld));
      if (mdl_vld && sb.size() > 0) begin
        chk("alu_a", bus.alu_a, sb[0].a);
        chk("alu_b", bus.alu_b, sb[0].b);
        chk("alu_op", 32'(bus.alu_op), 32'(sb[0].op));
        chk("rt_data", bus.rt_data, sb[0].rt);
      end
      acc = bus.in_valid && (!mdl_vld || bus.out_ready);
      if (mdl_vld && bus.out_ready && sb.size() > 0) void'(sb.pop_front());
      if (acc) begin
        e.a  = mrd(bus.rs_addr);
        e.rt = mrd(bus.rt_addr);
        e.b  = !bus.use_imm ? e.rt
             : bus.imm_zext ? {16'h0, bus.imm16} : {{16{bus.imm16[15]}}, bus.imm16};
        e.op = bus.op_in;
        sb.push_back(e);
      end
      mdl_vld = acc ? 1'b1 : (bus.out_ready ? 1'b0 : mdl_vld);
      if (bus.wr_en && bus.wr_addr != 5'd0) mregs[bus.wr_addr] = bus.wr_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                       input logic ui, input logic zx, input logic [2:0] op);
    bus.in_valid = 1'b1;
    bus.rs_addr  = rs;
    bus.rt_addr  = rt;
    bus.imm16    = imm;
    bus.use_imm  = ui;
    bus.imm_zext = zx;
    bus.op_in    = op;
  endtask

  task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.wr_en   = en;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.rs_addr = '0; bus.rt_addr = '0; bus.imm16 = '0;
    bus.use_imm = 1'b0; bus.imm_zext = 1'b0; bus.op_in = '0; bus.out_ready = 1'b0;
    wr(1'b0, 5'd0, 32'h0);
    step(); step();
    rst = 1'b0;
    chk("rst_vld", 32'(bus.out_valid), 32'h0);
    chk("rst_a", bus.alu_a, 32'h0);

    // 1: reset regs read zero
    bus.out_ready = 1'b1;
    issue(5'd5, 5'd6, 16'h0, 1'b0, 1'b0, 3'(ALU_ADD));
    step();
    bus.in_valid = 1'b0;
    chk("t1_vld", 32'(bus.out_valid), 32'h1);
    chk("t1_a", bus.alu_a, 32'h0);
    chk("t1_b", bus.alu_b, 32'h0);
    step();

    // 2: immediate sign/zero extension
    wr(1'b1, 5'd3, 32'h0000_00A5);
    step();
    wr(1'b0, 5'd0, 32'h0);
    issue(5'd3, 5'd0, 16'hFFFE, 1'b1, 1'b0, 3'(ALU_ADD));
    step();
    chk("t2_a", bus.alu_a, 32'h0000_00A5);
    chk("t2_b_sext", bus.alu_b, 32'hFFFF_FFFE);
    chk("t2_op", 32'(bus.alu_op), 32'd2);
    issue(5'd3, 5'd0, 16'hFFFE, 1'b1, 1'b1, 3'(ALU_ADD));
    step();
    chk("t2_b_zext", bus.alu_b, 32'h0000_FFFE);

    // 3: writes to $0 are dropped
    wr(1'b1, 5'd0, 32'hDEAD_BEEF);
    issue(5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 3'(ALU_OR));
    step();
    wr(1'b0, 5'd0, 32'h0);
    step();
    chk("t3_a", bus.alu_a, 32'h0);

    // 4: same-cycle write and read
    wr(1'b1, 5'd7, 32'h0000_1234);
    issue(5'd7, 5'd7, 16'h0, 1'b0, 1'b0, 3'(ALU_SUB));
    step();
    wr(1'b0, 5'd0, 32'h0);
`ifdef REGFILE_BYPASS_EN
    chk("t4_a", bus.alu_a, 32'h0000_1234);
`else
    chk("t4_a", bus.alu_a, 32'h0);
`endif
    step();
    chk("t4_a_next", bus.alu_a, 32'h0000_1234);
    bus.in_valid = 1'b0;
    step();

    // 5: stall then back-to-back ops
    for (int i = 1; i < 32; i++) begin
      wr(1'b1, 5'(i), $urandom);
      step();
    end
    wr(1'b0, 5'd0, 32'h0);
    bus.out_ready = 1'b0;
    issue(5'd1, 5'd2, 16'h8001, 1'b1, 1'b0, 3'(ALU_AND));
    step();
    issue(5'd4, 5'd9, 16'h7FFF, 1'b1, 1'b0, 3'(ALU_SLT));
    for (int i = 0; i < 3; i++) begin
      chk("t5_stall_rdy", 32'(bus.in_ready), 32'h0);
      step();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(5'($urandom), 5'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom_range(0, 4)));
      step();
    end
    bus.in_valid = 1'b0;
    step();

    // random mix of writes, issues and backpressure
    for (int i = 0; i < 60; i++) begin
      wr(1'($urandom), 5'($urandom), $urandom);
      if ($urandom_range(0, 3) != 0)
        issue(5'($urandom), 5'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
              3'($urandom_range(0, 4)));
      else
        bus.in_valid = 1'b0;
      bus.out_ready = 1'($urandom);
      step();
    end
    wr(1'b0, 5'd0, 32'h0);

    // 6: reset while holding a stalled entry
    bus.out_ready = 1'b0;
    issue(5'd1, 5'd1, 16'h0, 1'b0, 1'b0, 3'(ALU_ADD));
    step();
    bus.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_vld", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 1'b1;
    for (int i = 1; i < 32; i++) begin
      issue(5'(i), 5'(i), 16'h0, 1'b0, 1'b0, 3'(ALU_OR));
      step();
      chk("t6_reg_zero", bus.alu_a | bus.rt_data, 32'h0);
    end
    bus.in_valid = 1'b0;
    step(); step();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
